// File: rtl/truth_table_scanner.sv
// Sweeps every input vector through an external combinational block and packs the sampled
// outputs into per-output truth tables. Define MAXTERM_CHECK_EN to compare them against exp_i.
module truth_table_scanner #(
    parameter int unsigned N_IN       = 3,
    parameter int unsigned N_OUT      = 5,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [N_IN-1:0]               xyz_o,
    input  logic [N_OUT-1:0]              s_i,
    input  logic [N_OUT*(2**N_IN)-1:0]    exp_i,
    output logic                          busy,
    output logic                          done,
    output logic [N_OUT*(2**N_IN)-1:0]    table_o,
    output logic [N_OUT-1:0]              pass_o
);

    localparam int unsigned DEPTH = 2**N_IN;
    localparam int unsigned TW    = N_OUT * DEPTH;
    localparam int unsigned CNT_W = 4;

    localparam logic [N_IN-1:0]  LAST_VEC  = N_IN'(DEPTH - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    // With no settle time a freshly driven vector is captured on the very next edge
    localparam state_t VEC_STATE = (SETTLE_CYC == 0) ? S_CAPTURE : S_SETTLE;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N_IN-1:0]  r_xyz;
    logic             r_busy;
    logic             r_done;
    logic [TW-1:0]    r_table;
    logic [N_OUT-1:0] r_pass;

    logic [TW-1:0]    w_cap;
    logic [N_OUT-1:0] w_pass;

    // Table as it will be after the current vector's samples are written
    always_comb begin
        w_cap = r_table;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            for (int unsigned v = 0; v < DEPTH; v++) begin
                if (r_xyz == N_IN'(v)) begin
                    w_cap[j*DEPTH + v] = s_i[j];
                end
            end
        end
    end

`ifdef MAXTERM_CHECK_EN
    always_comb begin
        w_pass = '0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            w_pass[j] = (w_cap[j*DEPTH +: DEPTH] == exp_i[j*DEPTH +: DEPTH]);
        end
    end
`else
    logic w_unused_exp;
    assign w_unused_exp = ^exp_i;
    assign w_pass       = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_xyz   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= '0;
            r_pass  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_xyz   <= '0;
                        r_table <= '0;
                        r_pass  <= '0;
                        r_cnt   <= SETTLE_LD;
                        r_busy  <= 1'b1;
                        r_state <= VEC_STATE;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_table <= w_cap;
                    if (r_xyz == LAST_VEC) begin
                        r_pass  <= w_pass;
                        r_state <= S_DONE;
                    end else begin
                        r_xyz   <= r_xyz + N_IN'(1);
                        r_cnt   <= SETTLE_LD;
                        r_state <= VEC_STATE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_xyz   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign xyz_o   = r_xyz;
    assign busy    = r_busy;
    assign done    = r_done;
    assign table_o = r_table;
    assign pass_o  = r_pass;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three instances (SETTLE_CYC = 1, 0, 3) swept against
// random and maxterm-derived truth tables held in a behavioural model.
module tb_truth_table_scanner;

    localparam int unsigned N_IN  = 3;
    localparam int unsigned N_OUT = 5;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TW    = N_OUT * DEPTH;
    localparam int          N_DUT = 3;
    localparam int          WIN   = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic             start_v [N_DUT];
    logic [N_IN-1:0]  xyz_v   [N_DUT];
    logic [N_OUT-1:0] s_v     [N_DUT];
    logic             busy_v  [N_DUT];
    logic             done_v  [N_DUT];
    logic [TW-1:0]    table_v [N_DUT];
    logic [N_OUT-1:0] pass_v  [N_DUT];
    logic [TW-1:0]    exp_bus;

    logic [DEPTH-1:0] fn [N_OUT];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    truth_table_scanner #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYC(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .xyz_o(xyz_v[0]), .s_i(s_v[0]),
        .exp_i(exp_bus), .busy(busy_v[0]), .done(done_v[0]), .table_o(table_v[0]),
        .pass_o(pass_v[0])
    );

    truth_table_scanner #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYC(0)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .xyz_o(xyz_v[1]), .s_i(s_v[1]),
        .exp_i(exp_bus), .busy(busy_v[1]), .done(done_v[1]), .table_o(table_v[1]),
        .pass_o(pass_v[1])
    );

    truth_table_scanner #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYC(3)) u_dut_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .xyz_o(xyz_v[2]), .s_i(s_v[2]),
        .exp_i(exp_bus), .busy(busy_v[2]), .done(done_v[2]), .table_o(table_v[2]),
        .pass_o(pass_v[2])
    );

    // Behavioural function block: output j at vector v is bit v of fn[j]
    always_comb begin
        for (int i = 0; i < N_DUT; i++) begin
            for (int j = 0; j < N_OUT; j++) begin
                s_v[i][j] = fn[j][xyz_v[i]];
            end
        end
    end

    function automatic int settle_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [DEPTH-1:0] pi_m(input int a, input int b, input int c);
        logic [DEPTH-1:0] f;
        f    = '1;
        f[a] = 1'b0;
        f[b] = 1'b0;
        f[c] = 1'b0;
        return f;
    endfunction

    function automatic logic [TW-1:0] model_table();
        logic [TW-1:0] t;
        for (int j = 0; j < N_OUT; j++) t[j*DEPTH +: DEPTH] = fn[j];
        return t;
    endfunction

    function automatic logic [N_OUT-1:0] model_pass();
        logic [N_OUT-1:0] p;
        p = '0;
`ifdef MAXTERM_CHECK_EN
        for (int j = 0; j < N_OUT; j++) p[j] = (fn[j] == exp_bus[j*DEPTH +: DEPTH]);
`endif
        return p;
    endfunction

    // Vector on xyz_o in the cycle that begins k edges after the start-sampling edge
    function automatic logic [N_IN-1:0] exp_xyz(input int k, input int s);
        int per;
        per = s + 1;
        if (k < int'(DEPTH) * per)       return N_IN'(k / per);
        else if (k == int'(DEPTH) * per) return N_IN'(DEPTH - 1);
        else                             return '0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic check_idle(input string pfx);
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("%s_xyz%0d", pfx, i),   64'(xyz_v[i]),   64'd0);
            check($sformatf("%s_busy%0d", pfx, i),  64'(busy_v[i]),  64'd0);
            check($sformatf("%s_done%0d", pfx, i),  64'(done_v[i]),  64'd0);
            check($sformatf("%s_table%0d", pfx, i), 64'(table_v[i]), 64'd0);
            check($sformatf("%s_pass%0d", pfx, i),  64'(pass_v[i]),  64'd0);
        end
    endtask

    // Start all instances together; instance 0 optionally gets extra start pulses at edges re_a/re_b
    task automatic run_sweep(input string name, input int re_a, input int re_b);
        int cnt   [N_DUT];
        int first [N_DUT];
        int s;
        for (int i = 0; i < N_DUT; i++) begin
            cnt[i]   = 0;
            first[i] = -1;
        end
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) start_v[i] = 1'b1;
        for (int k = 0; k <= WIN; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_DUT; i++) start_v[i] = 1'b0;
            start_v[0] = (k + 1 == re_a) || (k + 1 == re_b);
            for (int i = 0; i < N_DUT; i++) begin
                s = settle_of(i);
                check($sformatf("%s_xyz%0d_e%0d", name, i, k), 64'(xyz_v[i]), 64'(exp_xyz(k, s)));
                check($sformatf("%s_busy%0d_e%0d", name, i, k), 64'(busy_v[i]),
                      64'(k <= int'(DEPTH) * (s + 1)));
                if (done_v[i] === 1'b1) begin
                    cnt[i]++;
                    if (first[i] < 0) first[i] = k;
                end
            end
        end
        for (int i = 0; i < N_DUT; i++) begin
            s = settle_of(i);
            check($sformatf("%s_done_cnt%0d", name, i), 64'(cnt[i]), 64'd1);
            check($sformatf("%s_done_edge%0d", name, i), 64'(first[i]),
                  64'(int'(DEPTH) * (s + 1) + 1));
            check($sformatf("%s_table%0d", name, i), 64'(table_v[i]), 64'(model_table()));
            check($sformatf("%s_pass%0d", name, i), 64'(pass_v[i]), 64'(model_pass()));
        end
    endtask

    task automatic mid_reset();
        int  cnt;
        bit  hit;
        hit = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        for (int k = 0; k < 30 && !hit; k++) begin
            @(posedge clk);
            #1;
            if (xyz_v[0] == N_IN'(4)) hit = 1'b1;
        end
        check("midrst_reach_xyz4", 64'(xyz_v[0]), 64'd4);
        #2 rst_n = 1'b0;
        #1;
        check_idle("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_v[0] === 1'b1) cnt++;
        end
        check("midrst_no_done", 64'(cnt), 64'd0);
        check("midrst_idle_xyz", 64'(xyz_v[0]), 64'd0);
    endtask

    task automatic load_maxterm();
        fn[0] = pi_m(1, 5, 7);
        fn[1] = pi_m(0, 4, 6);
        for (int j = 2; j < N_OUT; j++) fn[j] = DEPTH'($urandom);
        exp_bus = model_table();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N_DUT; i++) start_v[i] = 1'b0;
        for (int j = 0; j < N_OUT; j++) fn[j] = '0;
        exp_bus = '0;

        // Reset then idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("idle_c1");
        repeat (19) @(posedge clk);
        #1;
        check_idle("idle_c20");

        // Maxterm model with matching expectations
        load_maxterm();
        run_sweep("maxterm", -1, -1);
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("maxterm_s1_%0d", i), 64'(table_v[i][7:0]),  64'h5D);
            check($sformatf("maxterm_s2_%0d", i), 64'(table_v[i][15:8]), 64'hAE);
        end

        // Model disagrees with s1 expectation at vector 5
        fn[0] = pi_m(1, 5, 7) ^ DEPTH'(8'h20);
        run_sweep("corrupt", -1, -1);

        // Extra start pulses while busy are ignored
        load_maxterm();
        run_sweep("busyprot", 3, 10);

        // Reset mid-sweep, then a clean sweep
        mid_reset();
        load_maxterm();
        run_sweep("post_rst", -1, -1);

        // Random functions with partially mismatching expectations
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < N_OUT; j++) fn[j] = DEPTH'($urandom);
            exp_bus = model_table();
            for (int j = 0; j < N_OUT; j++) begin
                if ($urandom_range(0, 1) == 1) exp_bus[j*DEPTH + $urandom_range(0, DEPTH-1)] ^= 1'b1;
            end
            run_sweep($sformatf("rand%0d", r), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
